// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: bit-reverse helper, complex-word field split, bank pointer type.
package fft_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int REAL_HI   = DEF_WIDTH - 1;
  localparam int REAL_LO   = DEF_WIDTH / 2;

  typedef logic bank_ptr_t;

  // Reverses the low w bits of idx; bits at and above w come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_loader.sv
// Collects serial real samples into bit-reversed complex frames, ping-pong buffered.
// frame_valid rises the cycle after the last sample of a frame; input stalls while both banks are full.
module fft_bitrev_loader
  import fft_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IDX_W  = $clog2(SAMPLES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH/2-1:0]              sample_in,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic [SAMPLES-1:0][WIDTH-1:0]   frame_out,
  output logic                            frame_valid,
  input  logic                            frame_ready
);

  localparam int HALF = WIDTH / 2;

  logic [SAMPLES-1:0][WIDTH-1:0] bank [2];
  logic [1:0]                    full;
  bank_ptr_t                     wr_bank;
  bank_ptr_t                     rd_bank;
  logic [IDX_W-1:0]              wr_idx;
  logic [31:0]                   slot;
  logic                          accept;
  logic                          consume;
  logic                          last;

  assign sample_ready = !reset && !full[wr_bank];
  assign frame_valid  = full[rd_bank];
  assign frame_out    = bank[rd_bank];

  assign accept  = sample_valid && sample_ready;
  assign consume = frame_valid && frame_ready;
  assign last    = (wr_idx == IDX_W'(SAMPLES - 1));
  assign slot    = bit_reverse(32'(wr_idx), IDX_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      bank[0] <= '0;
      bank[1] <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (accept) begin
        for (int s = 0; s < SAMPLES; s++) begin
          if (32'(s) == slot) bank[wr_bank][s] <= {sample_in, {HALF{1'b0}}};
        end
        if (last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      // A consume always targets the other bank from a completing write, so the flag updates never collide.
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Randomized and directed bench for fft_bitrev_loader against a frame-queue reference model.
module tb_fft_bitrev_loader;
  import fft_pkg::*;

  typedef logic [3:0][31:0] frm_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  frm_t        frame_out;
  logic        frame_valid;
  logic        frame_ready = 1'b0;

  logic [15:0]         sample_in8 = '0;
  logic                sample_valid8 = 1'b0;
  logic                sample_ready8;
  logic [7:0][31:0]    frame_out8;
  logic                frame_valid8;
  logic                frame_ready8 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int m_consumed = 0;

  frm_t        held_q[$];
  logic [15:0] part_q[$];

  fft_bitrev_loader #(.SAMPLES(4), .WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ready(frame_ready)
  );

  fft_bitrev_loader #(.SAMPLES(8), .WIDTH(32)) u_dut8 (
    .clk(clk), .reset(reset), .sample_in(sample_in8), .sample_valid(sample_valid8),
    .sample_ready(sample_ready8), .frame_out(frame_out8), .frame_valid(frame_valid8),
    .frame_ready(frame_ready8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit reversal by repeated halving, independent of the package helper.
  function automatic int ref_rev(input int x, input int bits);
    int r = 0;
    for (int k = 0; k < bits; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model, cross the edge.
  task automatic step(input logic sv, input logic [15:0] s, input logic fr);
    bit   m_ready;
    frm_t f;
    sample_valid = sv;
    sample_in    = s;
    frame_ready  = fr;
    #1;
    m_ready = (held_q.size() < 2);
    check("sample_ready", sample_ready, m_ready);
    check("frame_valid", frame_valid, held_q.size() > 0);
    if (held_q.size() > 0) check("frame_out", frame_out, held_q[0]);
    if (fr && held_q.size() > 0) begin
      void'(held_q.pop_front());
      m_consumed++;
    end
    if (sv && m_ready) begin
      part_q.push_back(s);
      if (part_q.size() == 4) begin
        for (int i = 0; i < 4; i++) f[ref_rev(i, 2)] = {part_q[i], 16'h0000};
        held_q.push_back(f);
        part_q.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'($urandom);
    frame_ready  = 1'($urandom);
    #1;
    check("ready_in_reset", sample_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset        = 1'b0;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    held_q.delete();
    part_q.delete();
    #1;
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_out", frame_out, '0);
  endtask

  initial begin
    int c0;
    logic [15:0] exp8 [8];
    @(negedge clk);
    do_reset();

    // Scenario 1: four samples, no consume.
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
    check("s1_valid", frame_valid, 1'b1);
    check("s1_frame", frame_out, {32'h00040000, 32'h00020000, 32'h00030000, 32'h00010000});

    // Scenario 2: second bank fills, then input stalls.
    for (int i = 5; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0);
    check("s2_stall", sample_ready, 1'b0);
    check("s2_first_held", frame_out, {32'h00040000, 32'h00020000, 32'h00030000, 32'h00010000});

    // Scenario 3: one consume pulse switches to the second frame.
    step(1'b0, 16'h0, 1'b1);
    check("s3_frame2", frame_out, {32'h00080000, 32'h00060000, 32'h00070000, 32'h00050000});
    check("s3_ready", sample_ready, 1'b1);

    // Scenario 4: continuous consume, gapped stream of 12 samples incl. a negative value.
    step(1'b0, 16'h0, 1'b1);
    c0 = m_consumed;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) step(1'b1, (i == 2) ? 16'hFFFF : 16'($urandom), 1'b1);
      else            step(1'b0, 16'($urandom), 1'b1);
    end
    step(1'b0, 16'h0, 1'b1);
    check("s4_pulses", 32'(m_consumed - c0), 32'd3);

    // Scenario 5a: reset after two samples of a frame.
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0);
    check("s5a_clean", frame_out, {32'h0A030000, 32'h0A010000, 32'h0A020000, 32'h0A000000});

    // Scenario 5b: reset while a frame is held.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0);
    check("s5b_partial", frame_valid, 1'b0);
    step(1'b1, 16'h0B03, 1'b0);
    check("s5b_clean", frame_out, {32'h0B030000, 32'h0B010000, 32'h0B020000, 32'h0B000000});

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0));

    // Scenario 6: SAMPLES=8 instance.
    exp8 = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
    for (int v = 0; v < 8; v++) begin
      sample_valid8 = 1'b1;
      sample_in8    = 16'(v);
      #1;
      check("s6_ready", sample_ready8, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    sample_valid8 = 1'b0;
    #1;
    check("s6_valid", frame_valid8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s6_real%0d", i), frame_out8[i][REAL_HI:REAL_LO], exp8[i]);
      check($sformatf("s6_imag%0d", i), frame_out8[i][REAL_LO-1:0], 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
Input stage directly upstream of the FFT butterfly stages. It collects a serial stream of real audio samples into a full FFT frame. Each sample is written to its bit-reversed slot and packed as a complex word. The finished frame is presented in parallel as the sampleInputs vector of stage 0. Ping-pong buffering lets one frame be collected while the previous frame is held for the FFT.

Parameters:
SAMPLES, 4, points per frame; power of two, >= 2
WIDTH, 32, complex word width; upper WIDTH/2 bits real, lower WIDTH/2 bits imaginary, both signed two's complement
IDX_W, $clog2(SAMPLES), derived sample index width; not overridden

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sample_in  input  WIDTH/2  signed real sample
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  loader accepts sample_in this cycle
frame_out  output  [WIDTH-1:0] x [SAMPLES-1:0]  bit-reversed complex frame, feeds FFT stage 0
frame_valid  output  1  frame_out holds a complete frame
frame_ready  input  1  downstream consumes frame_out this cycle

Behaviour:
- Storage and state:
  - Two banks of SAMPLES x WIDTH registers.
  - full[1:0]: one flag per bank.
  - wr_bank and rd_bank: 1-bit bank pointers.
  - wr_idx: IDX_W-bit write index.
- Reset (sync, active-high):
  - All bank words, full, wr_bank, rd_bank and wr_idx go to 0.
  - frame_valid = 0 and frame_out is all zero from the next edge.
  - sample_ready is forced to 0 while reset is high.
  - Reset mid-frame discards any partial frame and any held frame; no frame_valid pulse follows.
- Combinational outputs:
  - sample_ready = !reset && !full[wr_bank]
  - frame_valid = full[rd_bank]
  - frame_out = bank[rd_bank]
- Accept (sample_valid && sample_ready), taking effect at the clock edge:
  - bank[wr_bank][bitrev(wr_idx)] <= {sample_in, (WIDTH/2)'0}; the imaginary part is always zero.
  - If wr_idx == SAMPLES-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
  - Otherwise wr_idx increments.
- Consume (frame_valid && frame_ready), taking effect at the clock edge:
  - full[rd_bank] <= 0 and rd_bank toggles.
  - Bank contents are not cleared; they are overwritten by the next fill.
- Latency: frame_valid rises the cycle after the edge that accepts the last sample of a frame.
- Simultaneous accept-completion and consume: both take effect. They always target different banks, because a consume requires full[rd_bank]=1 while writing requires full[wr_bank]=0.
- Both banks full: sample_ready = 0 and input stalls. The first consume frees a bank, and sample_ready is 1 in the next cycle.
- Frames are delivered in arrival order. No sample is ever dropped or overwritten while its bank is full.
- frame_out is stable while frame_valid=1 and frame_ready=0.
- sample_valid is ignored whenever sample_ready = 0.
- bitrev examples:
  - SAMPLES=4: 0->0, 1->2, 2->1, 3->3.
  - SAMPLES=8: 1->4, 3->6, 6->3.

Decomposition:
- Shared package fft_pkg holds:
  - function bit_reverse(idx, IDX_W);
  - the complex-word field split constants (REAL_HI = WIDTH-1, REAL_LO = WIDTH/2);
  - the 1-bit bank pointer typedef.
- No sub-module is warranted. The bank array, pointers and flags stay in one module.

Test Plan:
1. Reset, then feed 16'h0001, 0002, 0003, 0004 back-to-back with frame_ready=0 (SAMPLES=4) -> the cycle after the 4th accept, frame_valid=1 and frame_out = {00010000, 00030000, 00020000, 00040000} for index 0..3.
2. Continue with frame_ready=0 and feed 4 more samples -> the second bank fills. After the 8th accept sample_ready=0, and further valid samples are not accepted. frame_out still shows the first frame.
3. From scenario 2, pulse frame_ready for one cycle -> frame_out switches to the second frame (e.g. inputs 5..8 -> {00050000, 00070000, 00060000, 00080000}) and sample_ready=1 the next cycle.
4. Keep frame_ready=1 and feed a continuous stream of 12 samples with sample_valid gapped every other cycle -> exactly 3 one-cycle frame_valid pulses, in order, with sample_ready never 0. Negative input 16'hFFFF appears as FFFF0000.
5. Assert reset after 2 of 4 samples (and in a second run while a frame is held) -> next cycle frame_valid=0, frame_out=0, wr_idx restarts. The next 4 samples produce a clean frame with no stale data.
6. SAMPLES=8 build: feed 0..7 -> frame_out real parts in index order 0,4,2,6,1,5,3,7.
